demux_tree: RTL and testbench

Pipelined 1:N demultiplexer with valid/ready flow control, built as a recursive tree of registered 1:2 stages, K levels deep. It steers one W-bit data item per cycle from a single upstream source to one of N downstream channels selected by a K-bit index. It performs the routing counterpart of the recursive N:1 mux, on the send path of the fabric. One pipeline register per tree level gives a fixed latency of K cycles and full throughput when all targets are ready.

---
 rtl/demux_tree.sv | 67 ++++++
 tb/tb_demux_tree.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_tree.sv
// Pipelined 1:N valid/ready demultiplexer built as a recursive tree of registered 1:2 stages.
// Each level adds one cycle of latency. Ready is combinational from the leaves back to a_ready.
module demux_tree #(
  parameter int N = 8,
  parameter int K = 3,
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           a_valid,
  output logic           a_ready,
  input  logic [W-1:0]   a_data,
  input  logic [K-1:0]   s,
  output logic [N-1:0]   y_valid,
  input  logic [N-1:0]   y_ready,
  output logic [N*W-1:0] y_data
);
  typedef struct packed {
    logic [K-1:0] sel;
    logic [W-1:0] data;
  } ent_t;

  logic v;
  ent_t ent;
  logic tgt_ready;

  // The stage accepts when empty, or when its held item leaves on this same edge.
  assign a_ready = !v || tgt_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v   <= 1'b0;
      ent <= '0;
    end else if (a_ready) begin
      v        <= a_valid;
      ent.sel  <= s;
      ent.data <= a_data;
    end
  end

  generate
    if (N == 2) begin : g_leaf
      assign y_valid   = {v & ent.sel[K-1], v & ~ent.sel[K-1]};
      assign y_data    = {ent.data, ent.data};
      assign tgt_ready = y_ready[ent.sel[K-1]];
    end else begin : g_node
      logic [1:0] cv;
      logic [1:0] cr;
      assign cv        = {v & ent.sel[K-1], v & ~ent.sel[K-1]};
      assign tgt_ready = cr[ent.sel[K-1]];
      // Branch 1 serves the upper half of the channels, branch 0 the lower half.
      for (genvar b = 0; b < 2; b++) begin : g_sub
        demux_tree #(.N(N/2), .K(K-1), .W(W)) u_sub (
          .clk     (clk),
          .rst_n   (rst_n),
          .a_valid (cv[b]),
          .a_ready (cr[b]),
          .a_data  (ent.data),
          .s       (ent.sel[K-2:0]),
          .y_valid (y_valid[b*(N/2) +: N/2]),
          .y_ready (y_ready[b*(N/2) +: N/2]),
          .y_data  (y_data[b*(N/2)*W +: (N/2)*W])
        );
      end
    end
  endgenerate
endmodule

// File: tb/tb_demux_tree.sv
// Bench for demux_tree at (N,K) = (8,3), (2,1), (16,4): directed steps plus random traffic
// checked against per-channel FIFOs stamped with acceptance cycle.
module tb_demux_tree;
  logic clk = 1'b0;
  logic rst_n;
  logic         av [3];
  logic         ar [3];
  logic [7:0]   ad [3];
  logic [3:0]   sx [3];
  logic [15:0]  yv [3];
  logic [15:0]  yr [3];
  logic [127:0] yd [3];

  logic [7:0]  yv0;
  logic [63:0] yd0;
  logic [1:0]  yv1;
  logic [15:0] yd1;
  logic [15:0] yv2;
  logic [127:0] yd2;

  assign yv[0] = {8'h0, yv0};
  assign yd[0] = {64'h0, yd0};
  assign yv[1] = {14'h0, yv1};
  assign yd[1] = {112'h0, yd1};
  assign yv[2] = yv2;
  assign yd[2] = yd2;

  demux_tree #(.N(8), .K(3), .W(8)) u_d8 (
    .clk(clk), .rst_n(rst_n), .a_valid(av[0]), .a_ready(ar[0]), .a_data(ad[0]),
    .s(sx[0][2:0]), .y_valid(yv0), .y_ready(yr[0][7:0]), .y_data(yd0));
  demux_tree #(.N(2), .K(1), .W(8)) u_d2 (
    .clk(clk), .rst_n(rst_n), .a_valid(av[1]), .a_ready(ar[1]), .a_data(ad[1]),
    .s(sx[1][0:0]), .y_valid(yv1), .y_ready(yr[1][1:0]), .y_data(yd1));
  demux_tree #(.N(16), .K(4), .W(8)) u_d16 (
    .clk(clk), .rst_n(rst_n), .a_valid(av[2]), .a_ready(ar[2]), .a_data(ad[2]),
    .s(sx[2]), .y_valid(yv2), .y_ready(yr[2]), .y_data(yd2));

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit exact = 1'b0;
  logic acc_last [3];
  int qd [3][16][$];
  int qt [3][16][$];
  logic held_v [3][16];
  logic [7:0] held_d [3][16];

  function automatic int nch(input int i);
    return (i == 0) ? 8 : (i == 1) ? 2 : 16;
  endfunction
  function automatic int kdep(input int i);
    return (i == 0) ? 3 : (i == 1) ? 1 : 4;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  function automatic int pending(input int i);
    int t = 0;
    for (int c = 0; c < 16; c++) t += qd[i][c].size();
    return t;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 3; i++) begin
      acc_last[i] = 1'b0;
      for (int c = 0; c < 16; c++) begin
        qd[i][c].delete();
        qt[i][c].delete();
        held_v[i][c] = 1'b0;
        held_d[i][c] = 8'h0;
      end
    end
  endtask

  // Sampled mid-cycle: records acceptances and checks deliveries/holds for one instance.
  task automatic observe(input int i);
    int n = nch(i);
    int ed, et;
    logic [7:0] dd;
    acc_last[i] = av[i] && ar[i];
    if (acc_last[i]) begin
      qd[i][sx[i]].push_back(int'(ad[i]));
      qt[i][sx[i]].push_back(cyc);
    end
    for (int p = 0; p < n / 2; p++)
      chk("pair_onehot", 32'(yv[i][2*p] & yv[i][2*p+1]), 32'd0);
    for (int c = 0; c < n; c++) begin
      dd = yd[i][c*8 +: 8];
      if (held_v[i][c]) begin
        chk("hold_valid", 32'(yv[i][c]), 32'd1);
        chk("hold_data", 32'(dd), 32'(held_d[i][c]));
      end
      held_v[i][c] = yv[i][c] && !yr[i][c];
      held_d[i][c] = dd;
      if (yv[i][c] && yr[i][c]) begin
        chk("deliv_expected", 32'(qd[i][c].size() > 0), 32'd1);
        if (qd[i][c].size() > 0) begin
          ed = qd[i][c].pop_front();
          et = qt[i][c].pop_front();
          chk("deliv_data", 32'(dd), 32'(ed));
          chk("latency_min", 32'((cyc - et) >= kdep(i)), 32'd1);
          if (exact) chk("latency_exact", 32'(cyc - et), 32'(kdep(i)));
        end
      end
    end
  endtask

  task automatic tick();
    #1;
    for (int i = 0; i < 3; i++) observe(i);
    @(negedge clk);
    cyc++;
  endtask

  task automatic send(input int i, input int s, input int d, input int bound);
    av[i] = 1'b1;
    sx[i] = 4'(s);
    ad[i] = 8'(d);
    for (int b = 0; b < bound; b++) begin
      tick();
      if (acc_last[i]) break;
    end
    chk("accept_in_time", 32'(acc_last[i]), 32'd1);
    av[i] = 1'b0;
  endtask

  task automatic rand_run(input int i, input int items);
    int sent = 0;
    int guard = 0;
    int n = nch(i);
    acc_last[i] = 1'b0;
    av[i] = 1'b0;
    while (sent < items && guard < items * 8) begin
      if (!av[i] || acc_last[i]) begin
        av[i] = ($urandom_range(0, 4) != 0);
        sx[i] = 4'($urandom_range(0, n - 1));
        ad[i] = 8'($urandom);
      end
      yr[i] = 16'($urandom | $urandom | $urandom);
      tick();
      guard++;
      if (acc_last[i]) sent++;
    end
    av[i] = 1'b0;
    yr[i] = 16'hFFFF;
    for (int k = 0; k < 8; k++) tick();
    chk("rand_count", 32'(sent), 32'(items));
    chk("rand_drain", 32'(pending(i)), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      av[i] = 1'b0; ad[i] = 8'h0; sx[i] = 4'h0; yr[i] = 16'hFFFF;
    end
    clear_model();
    rst_n = 1'b0;
    #3;
    for (int i = 0; i < 3; i++) begin
      chk("reset_yvalid", 32'(yv[i]), 32'd0);
      chk("reset_aready", 32'(ar[i]), 32'd1);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Sweep every channel back to back with all targets ready.
    exact = 1'b1;
    for (int s = 0; s < 8; s++) begin
      av[0] = 1'b1; sx[0] = 4'(s); ad[0] = 8'(8'h10 + s);
      tick();
      chk("sweep_ready", 32'(acc_last[0]), 32'd1);
      chk("sweep_onehot", 32'($countones(yv[0]) <= 1), 32'd1);
    end
    av[0] = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    chk("sweep_drain", 32'(pending(0)), 32'd0);

    // N=2: item visible right after its acceptance edge.
    send(1, 1, 8'h5A, 3);
    chk("n2_visible", 32'(yv[1]), 32'd2);
    chk("n2_data", 32'(yd[1][15:8]), 32'h5A);
    tick();
    chk("n2_drain", 32'(pending(1)), 32'd0);
    exact = 1'b0;

    // Head-of-line: channel 5 stalled, its path fills, then a channel-1 item is stuck.
    yr[0] = 16'hFFDF;
    send(0, 5, 8'hA5, 4);
    send(0, 2, 8'hB2, 4);
    send(0, 5, 8'hC5, 4);
    send(0, 0, 8'hD0, 4);
    send(0, 5, 8'hE5, 4);
    av[0] = 1'b1; sx[0] = 4'd1; ad[0] = 8'hF1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("hol_blocked", 32'(acc_last[0]), 32'd0);
    end
    chk("hol_pending5", 32'(qd[0][5].size()), 32'd3);
    yr[0] = 16'hFFFF;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (acc_last[0]) break;
    end
    chk("hol_release", 32'(acc_last[0]), 32'd1);
    av[0] = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    chk("hol_drain", 32'(pending(0)), 32'd0);

    // Stall hold on channel 3 for 10 cycles.
    yr[0] = 16'hFFF7;
    send(0, 3, 8'h33, 4);
    for (int k = 0; k < 6; k++) begin
      if (yv[0][3]) break;
      tick();
    end
    for (int k = 0; k < 10; k++) begin
      chk("stall_valid", 32'(yv[0][3]), 32'd1);
      chk("stall_data", 32'(yd[0][31:24]), 32'h33);
      tick();
    end
    yr[0] = 16'hFFFF;
    tick();
    chk("stall_drain", 32'(qd[0][3].size()), 32'd0);
    chk("stall_once", 32'(yv[0][3]), 32'd0);

    // Mid-stream reset: fill with everything stalled, then pulse reset between edges.
    yr[0] = 16'h0000;
    send(0, 6, 8'h66, 4);
    send(0, 1, 8'h61, 4);
    send(0, 4, 8'h64, 4);
    #3 rst_n = 1'b0;
    #2;
    chk("async_yvalid", 32'(yv[0]), 32'd0);
    chk("async_aready", 32'(ar[0]), 32'd1);
    #1 rst_n = 1'b1;
    clear_model();
    yr[0] = 16'hFFFF;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("no_stale", 32'(yv[0]), 32'd0);
    end

    // Random traffic and random backpressure on all three shapes.
    rand_run(0, 2000);
    rand_run(1, 5000);
    rand_run(2, 5000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
